keypad_scan_ctrl: RTL and testbench

Scan sequencer and event scheduler for the 4x4 matrix keypad. It drives the active-low row lines with a programmable dwell, samples the column lines at the end of each dwell, and debounces the full 16-key frame. Debounced state changes are converted into key events and queued in a small FIFO behind a valid/ready handshake. It sits between the keypad pins and the system bus/LED logic, replacing free-running per-clock row rotation.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_evt_fifo.sv | 59 +++++
 rtl/keypad_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// +----------------------------------------------------------------------+
// | keypad_pkg : shared constants, FSM state and event types for the     |
// |              4x4 keypad scan controller.                             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_NUM  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] code;
    logic       press;
  } evt_t;

endpackage

`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
// +----------------------------------------------------------------------+
// | keypad_evt_fifo : first-word fall-through key event FIFO with a      |
// |                   sticky overflow flag for dropped pushes.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic empty,
  output logic overflow
);

  localparam int AW = $clog2(DEPTH);

  evt_t        r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_overflow;
  logic        w_full;
  logic        w_do_pop;
  logic        w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign empty     = (r_wr == r_rd);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!w_full || w_do_pop);
  assign head      = r_mem[r_rd[AW-1:0]];
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= push_data;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      if (push && w_full && !w_do_pop) r_overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | keypad_scan_ctrl : 4x4 keypad row scanner, frame debouncer and key   |
// |                    event scheduler. Release events: KEYPAD_RELEASE_EVT_EN |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [KEY_COLS-1:0] COL,
  output logic [KEY_ROWS-1:0] ROW,
  output logic [KEY_NUM-1:0]  key_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [3:0]          evt_code,
  output logic                evt_press,
  output logic                overflow
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  state_t              r_state;
  logic [1:0]          r_row_idx;
  logic [CNT_W-1:0]    r_dwell;
  logic [3:0]          r_key_idx;
  logic [KEY_ROWS-1:0] r_row_drv;
  logic [KEY_NUM-1:0]  r_raw;
  logic [KEY_NUM-1:0]  r_prev;
  logic [3:0]          r_stable;
  logic [KEY_NUM-1:0]  r_key_state;

  logic                w_match;
  logic [3:0]          w_stable_next;
  logic                w_first;
  logic [3:0]          w_stable_eff;
  logic [KEY_NUM-1:0]  w_prev_eff;
  logic                w_new_val;
  logic                w_change;
  logic                w_push;
  evt_t                w_evt;
  evt_t                w_head;
  logic                w_empty;

  assign w_match       = (r_raw == r_prev);
  assign w_stable_next = !w_match ? 4'd0 :
                         (r_stable == 4'(DEBOUNCE_SCANS)) ? r_stable : r_stable + 4'd1;

  // Cycle 0 of COMMIT decides with the debounce values being written that cycle.
  assign w_first      = (r_key_idx == 4'd0);
  assign w_stable_eff = w_first ? w_stable_next : r_stable;
  assign w_prev_eff   = w_first ? r_raw : r_prev;
  assign w_new_val    = w_prev_eff[r_key_idx];
  assign w_change     = (r_state == COMMIT) && (w_stable_eff == 4'(DEBOUNCE_SCANS))
                        && (w_new_val != r_key_state[r_key_idx]);

`ifdef KEYPAD_RELEASE_EVT_EN
  assign w_push = w_change;
`else
  assign w_push = w_change && w_new_val;
`endif

  assign w_evt = '{code: r_key_idx, press: w_new_val};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row_idx   <= 2'd0;
      r_dwell     <= '0;
      r_key_idx   <= 4'd0;
      r_row_drv   <= 4'b1111;
      r_raw       <= '0;
      r_prev      <= '0;
      r_stable    <= 4'd0;
      r_key_state <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_row_drv <= 4'b1111;
          if (en) begin
            r_state   <= DRIVE;
            r_row_idx <= 2'd0;
            r_dwell   <= '0;
            r_row_drv <= 4'b1110;
          end
        end
        DRIVE: begin
          if (r_dwell == CNT_W'(SCAN_DIV - 1)) begin
            r_raw[{r_row_idx, 2'b00} +: KEY_COLS] <= ~COL;
            r_dwell <= '0;
            if (r_row_idx == 2'(KEY_ROWS - 1)) begin
              r_state   <= COMMIT;
              r_key_idx <= 4'd0;
              r_row_drv <= 4'b1111;
            end else begin
              r_row_idx <= r_row_idx + 2'd1;
              r_row_drv <= ~(4'b0001 << (r_row_idx + 2'd1));
            end
          end else begin
            r_dwell <= r_dwell + CNT_W'(1);
          end
        end
        COMMIT: begin
          if (w_first) begin
            r_stable <= w_stable_next;
            r_prev   <= r_raw;
          end
          if (w_change) r_key_state[r_key_idx] <= w_new_val;
          if (r_key_idx == 4'd15) r_state <= IDLE;
          else r_key_idx <= r_key_idx + 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_evt),
    .pop       (evt_ready),
    .head      (w_head),
    .empty     (w_empty),
    .overflow  (overflow)
  );

  assign ROW       = r_row_drv;
  assign key_state = r_key_state;
  assign evt_valid = !w_empty;
  assign evt_code  = w_head.code;
  assign evt_press = w_head.press;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_keypad_scan_ctrl : directed bench for keypad_scan_ctrl with a     |
// |                       behavioural keypad matrix on ROW/COL.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_state;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_code;
  logic        evt_press;
  logic        overflow;
  logic [15:0] keys;

  int vectors = 0;
  int miscompares = 0;
  int rel = 0;

  always #5 clk = ~clk;

  // Closed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!row[r]) col = col & ~keys[4*r +: 4];
  end

  keypad_scan_ctrl #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .COL       (col),
    .ROW       (row),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .overflow  (overflow)
  );

  // Advance to just after posedge number m counted from the first DRIVE edge.
  task automatic goto(input int m);
    while (rel < m) begin
      @(posedge clk);
      rel++;
    end
    #1;
  endtask

  task automatic start_scan(input logic [15:0] k);
    rst = 1'b1; en = 1'b0; evt_ready = 1'b0; keys = k;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1;
    rel = -1;
    goto(0);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; evt_ready = 1'b0; keys = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (row !== 4'b1111) begin miscompares++; $display("FAIL reset_row got %b exp 1111", row); end
    vectors++; if (key_state !== 16'h0) begin miscompares++; $display("FAIL reset_keys got %h exp 0000", key_state); end
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", evt_valid); end
    vectors++; if (evt_code !== 4'h0) begin miscompares++; $display("FAIL reset_code got %h exp 0", evt_code); end
    vectors++; if (evt_press !== 1'b0) begin miscompares++; $display("FAIL reset_press got %b exp 0", evt_press); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_row;
    start_scan(16'h0000);
    for (int m = 0; m <= 33; m++) begin
      goto(m);
      exp_row = 4'b1111;
      if (m < 16) exp_row[m/4] = 1'b0;
      if (m == 33) exp_row = 4'b1110;
      vectors++; if (row !== exp_row) begin miscompares++; $display("FAIL scan_row m=%0d got %b exp %b", m, row, exp_row); end
      vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL scan_valid m=%0d got %b exp 0", m, evt_valid); end
    end
    goto(33*4);
    vectors++; if (key_state !== 16'h0) begin miscompares++; $display("FAIL scan_keys got %h exp 0000", key_state); end
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL scan_idle_valid got %b exp 0", evt_valid); end
  endtask

  task automatic test_press_release();
    start_scan(16'h0040);
    goto(88);
    vectors++; if (key_state !== 16'h0000) begin miscompares++; $display("FAIL press_early_keys got %h exp 0000", key_state); end
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL press_early_valid got %b exp 0", evt_valid); end
    goto(89);
    vectors++; if (key_state !== 16'h0040) begin miscompares++; $display("FAIL press_keys got %h exp 0040", key_state); end
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL press_valid got %b exp 1", evt_valid); end
    vectors++; if (evt_code !== 4'd6) begin miscompares++; $display("FAIL press_code got %0d exp 6", evt_code); end
    vectors++; if (evt_press !== 1'b1) begin miscompares++; $display("FAIL press_flag got %b exp 1", evt_press); end
    evt_ready = 1'b1;
    goto(90);
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL press_pop got %b exp 0", evt_valid); end
    goto(98);
    keys = 16'h0000;
    goto(187);
    vectors++; if (key_state !== 16'h0040) begin miscompares++; $display("FAIL rel_early_keys got %h exp 0040", key_state); end
    evt_ready = 1'b0;
    goto(188);
    vectors++; if (key_state !== 16'h0000) begin miscompares++; $display("FAIL rel_keys got %h exp 0000", key_state); end
`ifdef KEYPAD_RELEASE_EVT_EN
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL rel_valid got %b exp 1", evt_valid); end
    vectors++; if (evt_code !== 4'd6) begin miscompares++; $display("FAIL rel_code got %0d exp 6", evt_code); end
    vectors++; if (evt_press !== 1'b0) begin miscompares++; $display("FAIL rel_flag got %b exp 0", evt_press); end
`else
    goto(195);
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL rel_silent got %b exp 0", evt_valid); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rel_ovf got %b exp 0", overflow); end
`endif
  endtask

  task automatic test_glitch();
    start_scan(16'h0040);
    goto(65);
    keys = 16'h0000;
    goto(89);
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid got %b exp 0", evt_valid); end
    goto(33*5);
    vectors++; if (key_state !== 16'h0000) begin miscompares++; $display("FAIL glitch_keys got %h exp 0000", key_state); end
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_late_valid got %b exp 0", evt_valid); end
  endtask

  task automatic test_two_keys();
    start_scan(16'h1008);
    evt_ready = 1'b1;
    goto(86);
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL two_valid3 got %b exp 1", evt_valid); end
    vectors++; if (evt_code !== 4'd3) begin miscompares++; $display("FAIL two_code3 got %0d exp 3", evt_code); end
    vectors++; if (key_state !== 16'h0008) begin miscompares++; $display("FAIL two_keys3 got %h exp 0008", key_state); end
    goto(87);
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL two_gap got %b exp 0", evt_valid); end
    goto(95);
    vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL two_valid12 got %b exp 1", evt_valid); end
    vectors++; if (evt_code !== 4'd12) begin miscompares++; $display("FAIL two_code12 got %0d exp 12", evt_code); end
    vectors++; if (key_state !== 16'h1008) begin miscompares++; $display("FAIL two_keys12 got %h exp 1008", key_state); end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_codes [4];
    exp_codes = '{4'd0, 4'd1, 4'd2, 4'd5};
    start_scan(16'h0227);
    goto(91);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %b exp 0", overflow); end
    goto(92);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b exp 1", overflow); end
    vectors++; if (key_state !== 16'h0227) begin miscompares++; $display("FAIL ovf_keys got %h exp 0227", key_state); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      goto(92 + i);
      vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid%0d got %b exp 1", i, evt_valid); end
      vectors++; if (evt_code !== exp_codes[i]) begin miscompares++; $display("FAIL drain_code%0d got %0d exp %0d", i, evt_code, exp_codes[i]); end
    end
    goto(96);
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %b exp 0", evt_valid); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    goto(100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL midrst_ovf got %b exp 0", overflow); end
    vectors++; if (row !== 4'b1111) begin miscompares++; $display("FAIL midrst_row got %b exp 1111", row); end
    vectors++; if (key_state !== 16'h0) begin miscompares++; $display("FAIL midrst_keys got %h exp 0000", key_state); end
    vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b exp 0", evt_valid); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; evt_ready = 1'b0; keys = 16'h0000;
    test_reset();
    test_scan();
    test_press_release();
    test_glitch();
    test_two_keys();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
